// File: rtl/param_regbank.sv
// param_regbank: DEPTH x DATA_WIDTH register bank with pipelined reads and a
// sequential clear sweep that runs after reset or on request.
//   clk_i    - clock, all logic on the rising edge
//   rst_i    - asynchronous active-high reset (starts a clear sweep)
//   write_en - write request, accepted when ready
//   read_en  - read request, accepted when ready
//   addr     - request address (shared by read and write)
//   data_in  - write data
//   clear_i  - request to zero the whole bank (sampled in IDLE only)
//   data_out - registered read data, holds between reads
//   rd_valid - one-cycle strobe, RD_LATENCY cycles after an accepted read
//   ready    - high in IDLE; requests are ignored while low
module param_regbank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_acc;
  logic                  rd_acc;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [DATA_WIDTH-1:0] pipe_dat [RD_LATENCY];

  always_comb begin
    ready  = (state == IDLE);
    wr_acc = write_en & ready;
    rd_acc = read_en & ready;
  end

  // Sweep ends when the counter wraps from DEPTH-1 back to 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_i) state <= CLEAR;
        end
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == '1) state <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage has no reset; the sweep zeroes it one word per cycle.
  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      mem[sweep_cnt] <= '0;
    end else if (wr_acc) begin
      mem[addr] <= data_in;
    end
  end

  // Stage 0 samples the array at the accepting edge, so a same-cycle write
  // to the same address is not seen (read-before-write). The last stage is
  // the output register and only loads on a valid beat, so it holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) pipe_dat[0] <= mem[addr];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  always_comb begin
    rd_valid = pipe_vld[RD_LATENCY-1];
    data_out = pipe_dat[RD_LATENCY-1];
  end

endmodule

// File: tb/tb_param_regbank.sv
module tb_param_regbank;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          write_en;
  logic          read_en;
  logic          clear_i;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] d1, d3;
  logic          v1, v3, r1, r3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst_i), .write_en(write_en), .read_en(read_en),
    .addr(addr), .data_in(data_in), .clear_i(clear_i),
    .data_out(d1), .rd_valid(v1), .ready(r1)
  );

  param_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) u_lat3 (
    .clk_i(clk), .rst_i(rst_i), .write_en(write_en), .read_en(read_en),
    .addr(addr), .data_in(data_in), .clear_i(clear_i),
    .data_out(d3), .rd_valid(v3), .ready(r3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    write_en = 1'b0;
    read_en  = 1'b0;
    clear_i  = 1'b0;
  endtask

  task automatic count_ready_low(output int n);
    n = 0;
    while (r1 !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; data_in = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic read_and_check(input logic [AW-1:0] a, input logic [DW-1:0] e);
    addr = a; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    checks++; if (v1 !== 1'b1) begin errors++; $display("FAIL rd_valid_lat1 addr=%0d got=%b exp=1", a, v1); end
    checks++; if (d1 !== e) begin errors++; $display("FAIL data_lat1 addr=%0d got=%h exp=%h", a, d1, e); end
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL early_valid_lat3 addr=%0d got=%b exp=0", a, v3); end
    tick();
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL strobe_len_lat1 addr=%0d got=%b exp=0", a, v1); end
    checks++; if (d1 !== e) begin errors++; $display("FAIL hold_lat1 addr=%0d got=%h exp=%h", a, d1, e); end
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL early_valid_lat3 addr=%0d got=%b exp=0", a, v3); end
    tick();
    checks++; if (v3 !== 1'b1) begin errors++; $display("FAIL rd_valid_lat3 addr=%0d got=%b exp=1", a, v3); end
    checks++; if (d3 !== e) begin errors++; $display("FAIL data_lat3 addr=%0d got=%h exp=%h", a, d3, e); end
  endtask

  task automatic test_reset();
    int n;
    rst_i = 1'b1; idle_inputs(); addr = '0; data_in = '0;
    tick(); tick();
    checks++; if (r1 !== 1'b0 || r3 !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b/%b exp=0/0", r1, r3); end
    checks++; if (v1 !== 1'b0 || v3 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b/%b exp=0/0", v1, v3); end
    checks++; if (d1 !== 8'h00 || d3 !== 8'h00) begin errors++; $display("FAIL reset_data got=%h/%h exp=00/00", d1, d3); end
    rst_i = 1'b0;
    count_ready_low(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL reset_sweep_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) read_and_check(AW'(i), 8'h00);
  endtask

  task automatic test_write_read();
    write_word(4'd3, 8'hA5);
    read_and_check(4'd3, 8'hA5);
  endtask

  task automatic test_read_before_write();
    write_word(4'd5, 8'h11);
    addr = 4'd5; data_in = 8'h22; write_en = 1'b1; read_en = 1'b1;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    checks++; if (v1 !== 1'b1 || d1 !== 8'h11) begin errors++; $display("FAIL rbw_lat1 got=%b/%h exp=1/11", v1, d1); end
    tick(); tick();
    checks++; if (v3 !== 1'b1 || d3 !== 8'h11) begin errors++; $display("FAIL rbw_lat3 got=%b/%h exp=1/11", v3, d3); end
    read_and_check(4'd5, 8'h22);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    for (int i = 0; i < 4; i++) write_word(AW'(i), DW'(i + 1));
    for (int i = 0; i < 4; i++) begin
      addr = AW'(i); read_en = 1'b1;
      tick();
      e = DW'(i + 1);
      checks++; if (v1 !== 1'b1 || d1 !== e) begin errors++; $display("FAIL b2b_lat1 beat=%0d got=%b/%h exp=1/%h", i, v1, d1, e); end
      if (i >= 2) begin
        e = DW'(i - 1);
        checks++; if (v3 !== 1'b1 || d3 !== e) begin errors++; $display("FAIL b2b_lat3 beat=%0d got=%b/%h exp=1/%h", i, v3, d3, e); end
      end else begin
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL b2b_lat3_early beat=%0d got=%b exp=0", i, v3); end
      end
    end
    read_en = 1'b0;
    tick();
    checks++; if (v1 !== 1'b0 || d1 !== 8'h04) begin errors++; $display("FAIL b2b_lat1_hold got=%b/%h exp=0/04", v1, d1); end
    checks++; if (v3 !== 1'b1 || d3 !== 8'h03) begin errors++; $display("FAIL b2b_lat3_beat3 got=%b/%h exp=1/03", v3, d3); end
    tick();
    checks++; if (v3 !== 1'b1 || d3 !== 8'h04) begin errors++; $display("FAIL b2b_lat3_beat4 got=%b/%h exp=1/04", v3, d3); end
    tick();
    checks++; if (v3 !== 1'b0 || d3 !== 8'h04) begin errors++; $display("FAIL b2b_lat3_hold got=%b/%h exp=0/04", v3, d3); end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 16; i++) write_word(AW'(i), DW'(8'h10 + i));
    // clear together with a write and a read: both accepted this cycle
    addr = 4'd5; data_in = 8'hEE; write_en = 1'b1; read_en = 1'b1; clear_i = 1'b1;
    tick();
    n = 0;
    while (r1 !== 1'b1 && n < 100) begin
      if (n == 0) begin
        checks++; if (v1 !== 1'b1 || d1 !== 8'h15) begin errors++; $display("FAIL clr_inflight_lat1 got=%b/%h exp=1/15", v1, d1); end
      end else begin
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL clr_ignored_read_lat1 cyc=%0d got=%b exp=0", n, v1); end
      end
      if (n == 2) begin
        checks++; if (v3 !== 1'b1 || d3 !== 8'h15) begin errors++; $display("FAIL clr_inflight_lat3 got=%b/%h exp=1/15", v3, d3); end
      end else begin
        checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL clr_ignored_read_lat3 cyc=%0d got=%b exp=0", n, v3); end
      end
      // keep hammering requests and clear_i while the sweep runs
      addr = AW'(n); data_in = 8'hFF; write_en = 1'b1; read_en = 1'b1; clear_i = 1'b1;
      n++;
      tick();
    end
    idle_inputs();
    checks++; if (n !== 16) begin errors++; $display("FAIL clear_len got=%0d exp=16", n); end
    for (int i = 0; i < 16; i++) read_and_check(AW'(i), 8'h00);
  endtask

  task automatic test_reset_mid_flight();
    int n;
    write_word(4'd7, 8'h77);
    addr = 4'd7; read_en = 1'b1;
    tick();
    read_en = 1'b0;
    checks++; if (v1 !== 1'b1 || d1 !== 8'h77) begin errors++; $display("FAIL pre_rst_read got=%b/%h exp=1/77", v1, d1); end
    rst_i = 1'b1;
    #1;
    checks++; if (v1 !== 1'b0 || d1 !== 8'h00 || r1 !== 1'b0) begin errors++; $display("FAIL async_rst_lat1 got=%b/%h/%b exp=0/00/0", v1, d1, r1); end
    checks++; if (v3 !== 1'b0 || d3 !== 8'h00) begin errors++; $display("FAIL async_rst_lat3 got=%b/%h exp=0/00", v3, d3); end
    tick(); tick(); tick();
    checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL rst_drop_inflight got=%b exp=0", v3); end
    rst_i = 1'b0;
    count_ready_low(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL rst_read_sweep_len got=%0d exp=16", n); end

    write_word(4'd10, 8'h5A);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (r1 !== 1'b0) begin errors++; $display("FAIL mid_sweep_ready got=%b exp=0", r1); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    count_ready_low(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL rst_mid_sweep_len got=%0d exp=16", n); end
    read_and_check(4'd10, 8'h00);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_before_write();
    test_back_to_back();
    test_clear();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_regbank.md
PARAM_REGBANK -- requirements
Module: param_regbank

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each storage word and of data_in/data_out.
REQ-002 Parameter ADDR_WIDTH, default 4, address width; depth DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter RD_LATENCY, default 1, legal 1..3, cycles from accepted read to data_out valid.
REQ-004 Port list (one clock; reset is asynchronous and active-high):
- clk_i  input  1  single clock, all logic on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- write_en  input  1  write request.
- read_en  input  1  read request.
- addr  input  ADDR_WIDTH  request address.
- data_in  input  DATA_WIDTH  write data.
- clear_i  input  1  request to zero the entire bank.
- data_out  output  DATA_WIDTH  registered read data.
- rd_valid  output  1  one-cycle strobe, data_out valid.
- ready  output  1  block accepts requests this cycle.

Function
REQ-005 Storage is DEPTH x DATA_WIDTH words; no async reset on the array itself.
REQ-006 FSM states IDLE and CLEAR; ready = 1 only in IDLE.
REQ-007 Write accepted when write_en & ready: mem[addr] <= data_in at that edge.
REQ-008 Read accepted when read_en & ready: mem[addr] sampled at that edge; data_out updates and rd_valid pulses exactly RD_LATENCY cycles later.
REQ-009 Reads are pipelined: one accepted read per cycle, each with its own rd_valid pulse, order preserved.
REQ-010 write_en & read_en same cycle, same addr: write performed, read returns OLD contents (read-before-write).
REQ-011 write_en & read_en same cycle, different addr: both performed independently.
REQ-012 data_out holds its last value when rd_valid = 0.
REQ-013 Requests while ready = 0 are ignored (no write, no rd_valid); no queuing.
REQ-014 clear_i sampled in IDLE -> CLEAR next cycle; CLEAR zeroes address 0, 1, ..., DEPTH-1, one per cycle, via an internal ADDR_WIDTH counter.
REQ-015 CLEAR lasts exactly DEPTH cycles, then returns to IDLE; counter wrap from DEPTH-1 to 0 ends the sweep.
REQ-016 clear_i asserted in IDLE together with write_en/read_en: the request is still accepted that cycle (ready was 1); the clear starts next cycle and overwrites that write.
REQ-017 clear_i asserted during CLEAR is ignored; the sweep does not restart.
REQ-018 Reads in flight when CLEAR starts complete normally with pre-clear data.

Reset
REQ-019 rst_i asserted: asynchronously data_out = 0, rd_valid = 0, read pipeline valid bits = 0, sweep counter = 0, FSM = CLEAR, ready = 0.
REQ-020 After rst_i deasserts, the block performs the full DEPTH-cycle clear sweep and then enters IDLE with ready = 1; all words read 0.
REQ-021 rst_i asserted mid-sweep or mid-read discards all in-flight reads (no rd_valid) and restarts the sweep from address 0.

Verification
REQ-022 Defaults; release reset -> ready = 0 for 16 cycles, then 1; read each address -> data_out = 0x00.
REQ-023 Write 0xA5 to addr 3, then read addr 3 -> rd_valid one cycle later, data_out = 0xA5; RD_LATENCY = 3 -> three cycles later.
REQ-024 Preload addr 5 = 0x11; same cycle write 0x22 and read addr 5 -> data_out = 0x11; next read -> 0x22.
REQ-025 Back-to-back reads of addr 0..3 (holding 1,2,3,4) -> four consecutive rd_valid pulses, data 1,2,3,4.
REQ-026 Fill bank, pulse clear_i -> ready low exactly 16 cycles; writes during sweep have no effect; all reads afterwards = 0.
REQ-027 Assert rst_i at sweep address 7 with a read in flight -> no rd_valid; after release, the sweep runs a full 16 cycles from address 0.
